// File: rtl/mfcc_pkg.sv
// Shared types and saturation helpers for the MFCC front end.
package mfcc_pkg;

  localparam int unsigned DEF_DATA_W    = 16;
  localparam int unsigned DEF_COEF_W    = 18;
  localparam int unsigned DEF_COEF_FRAC = 14;
  localparam int unsigned DEF_ACC_W     = 32;

  // Working width for the saturation helpers; callers sign-extend into it.
  localparam int unsigned SAT_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UPDATE,
    ST_EMIT
  } gz_state_e;

  // Clamp v into the signed w-bit range.
  function automatic logic signed [SAT_W-1:0] sat_signed(
    input logic signed [SAT_W-1:0] v,
    input int unsigned             w
  );
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    logic signed [SAT_W-1:0] r;
    one = SAT_W'(1);
    hi  = (one <<< (w - 1)) - one;
    lo  = ~hi;
    if (v > hi)      r = hi;
    else if (v < lo) r = lo;
    else             r = v;
    return r;
  endfunction

  // Clamp v into the unsigned w-bit range (negative -> 0).
  function automatic logic signed [SAT_W-1:0] sat_unsigned(
    input logic signed [SAT_W-1:0] v,
    input int unsigned             w
  );
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] r;
    one = SAT_W'(1);
    hi  = (one <<< w) - one;
    if (v < 0)       r = '0;
    else if (v > hi) r = hi;
    else             r = v;
    return r;
  endfunction

endpackage

// File: rtl/goertzel_mac.sv
// Combinational Goertzel datapath: recurrence step and bin power, both saturated.
module goertzel_mac import mfcc_pkg::*; #(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned COEF_W    = DEF_COEF_W,
  parameter int unsigned COEF_FRAC = DEF_COEF_FRAC,
  parameter int unsigned ACC_W     = DEF_ACC_W,
  parameter int unsigned OUT_W     = 32
) (
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [COEF_W-1:0] coef,
  input  logic signed [ACC_W-1:0]  s1,
  input  logic signed [ACC_W-1:0]  s2,
  output logic signed [ACC_W-1:0]  s0,
  output logic        [OUT_W-1:0]  power
);

  // Recurrence width holds the full coef*s1 product plus headroom for +x -s2.
  localparam int unsigned RW = ACC_W + COEF_W + 2;
  // Power width holds coef*s1*s2 plus headroom for the sum of squares.
  localparam int unsigned PW = 2 * ACC_W + COEF_W + 2;

  logic signed [RW-1:0] r_x, r_c, r_s1, r_s2, r_prod, r_sum;
  logic signed [PW-1:0] p_c, p_s1, p_s2, p_sum;

  // s0 = x + floor(coef*s1 / 2^FRAC) - s2 and P = s1^2 + s2^2 - floor(coef*s1*s2 / 2^FRAC).
  always_comb begin
    r_x    = RW'(x);
    r_c    = RW'(coef);
    r_s1   = RW'(s1);
    r_s2   = RW'(s2);
    r_prod = r_c * r_s1;
    r_sum  = r_x + (r_prod >>> COEF_FRAC) - r_s2;
    s0     = ACC_W'(sat_signed(SAT_W'(r_sum), ACC_W));

    p_c    = PW'(coef);
    p_s1   = PW'(s1);
    p_s2   = PW'(s2);
    p_sum  = p_s1 * p_s1 + p_s2 * p_s2 - ((p_c * p_s1 * p_s2) >>> COEF_FRAC);
    power  = OUT_W'(sat_unsigned(SAT_W'(p_sum), OUT_W));
  end

endmodule

// File: rtl/goertzel_bank.sv
// Time-multiplexed Goertzel filter bank: one bin per cycle through a shared MAC,
// per-bin power streamed out over valid/ready at end of frame.
module goertzel_bank import mfcc_pkg::*; #(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned COEF_W    = DEF_COEF_W,
  parameter int unsigned COEF_FRAC = DEF_COEF_FRAC,
  parameter int unsigned ACC_W     = DEF_ACC_W,
  parameter int unsigned OUT_W     = 32,
  parameter int unsigned NUM_BINS  = 32,
  localparam int unsigned BIN_W    = $clog2(NUM_BINS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  input  logic [BIN_W:0]    num_bins,
  input  logic              coef_we,
  input  logic [BIN_W-1:0]  coef_addr,
  input  logic [COEF_W-1:0] coef_wdata,
  output logic              coef_busy,
  output logic [OUT_W-1:0]  out_power,
  output logic [BIN_W-1:0]  out_bin,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [BIN_W:0]   NB_MAX  = (BIN_W + 1)'(NUM_BINS);
  localparam logic [BIN_W:0]   NB_ONE  = (BIN_W + 1)'(1);
  localparam logic [BIN_W-1:0] BIN_ONE = BIN_W'(1);

  gz_state_e                state_q, state_d;
  logic [BIN_W-1:0]         bin_q, bin_d;
  logic [BIN_W:0]           nb_q, nb_d;
  logic signed [DATA_W-1:0] x_q, x_d;
  logic                     last_q, last_d;
  logic                     busy_q, busy_d;

  logic signed [ACC_W-1:0]  s1_q [NUM_BINS];
  logic signed [ACC_W-1:0]  s2_q [NUM_BINS];
  logic signed [COEF_W-1:0] coef_q [NUM_BINS];

  logic signed [ACC_W-1:0]  s1_rd, s2_rd, s0;
  logic signed [COEF_W-1:0] coef_rd;
  logic [OUT_W-1:0]         pow;
  logic                     st_we;
  logic signed [ACC_W-1:0]  s1_wd, s2_wd;
  logic                     bin_is_last;

  // Single read port into the state and coefficient arrays at the current bin.
  always_comb begin
    s1_rd   = s1_q[bin_q];
    s2_rd   = s2_q[bin_q];
    coef_rd = coef_q[bin_q];
  end

  goertzel_mac #(
    .DATA_W   (DATA_W),
    .COEF_W   (COEF_W),
    .COEF_FRAC(COEF_FRAC),
    .ACC_W    (ACC_W),
    .OUT_W    (OUT_W)
  ) u_mac (
    .x    (x_q),
    .coef (coef_rd),
    .s1   (s1_rd),
    .s2   (s2_rd),
    .s0   (s0),
    .power(pow)
  );

  // Next-state, state-array write request and handshake outputs.
  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    nb_d        = nb_q;
    x_d         = x_q;
    last_d      = last_q;
    busy_d      = busy_q;
    st_we       = 1'b0;
    s1_wd       = s0;
    s2_wd       = s1_rd;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_power   = '0;
    out_bin     = '0;
    out_last    = 1'b0;
    bin_is_last = ({1'b0, bin_q} == (nb_q - NB_ONE));

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          x_d     = in_data;
          last_d  = in_last;
          bin_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_UPDATE;
          if (!busy_q) begin
            nb_d = ((num_bins == '0) || (num_bins > NB_MAX)) ? NB_MAX : num_bins;
          end
        end
      end
      ST_UPDATE: begin
        st_we = 1'b1;
        s1_wd = s0;
        s2_wd = s1_rd;
        bin_d = bin_q + BIN_ONE;
        if (bin_is_last) begin
          bin_d   = '0;
          state_d = last_q ? ST_EMIT : ST_IDLE;
        end
      end
      ST_EMIT: begin
        out_valid = 1'b1;
        out_power = pow;
        out_bin   = bin_q;
        out_last  = bin_is_last;
        if (out_ready) begin
          st_we = 1'b1;
          s1_wd = '0;
          s2_wd = '0;
          bin_d = bin_q + BIN_ONE;
          if (bin_is_last) begin
            bin_d   = '0;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign coef_busy = busy_q;

  // Control registers and per-bin recurrence state; reset discards any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      nb_q    <= '0;
      x_q     <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      for (int unsigned i = 0; i < NUM_BINS; i++) begin
        s1_q[BIN_W'(i)] <= '0;
        s2_q[BIN_W'(i)] <= '0;
      end
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      nb_q    <= nb_d;
      x_q     <= x_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      if (st_we) begin
        s1_q[bin_q] <= s1_wd;
        s2_q[bin_q] <= s2_wd;
      end
    end
  end

  // Coefficient RAM survives reset; writes are dropped while a frame is open.
  always_ff @(posedge clk) begin
    if (coef_we && !busy_q) begin
      coef_q[coef_addr] <= coef_wdata;
    end
  end

endmodule

// File: tb/tb_goertzel_bank.sv
// Directed bench for goertzel_bank with a bin-level arithmetic model and scoreboard.
module tb_goertzel_bank;

  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [2:0]  num_bins;
  logic        coef_we;
  logic [1:0]  coef_addr;
  logic [17:0] coef_wdata;
  logic        coef_busy;
  logic [31:0] out_power;
  logic [1:0]  out_bin;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  always #5 clk = ~clk;

  goertzel_bank #(
    .DATA_W   (16),
    .COEF_W   (18),
    .COEF_FRAC(14),
    .ACC_W    (32),
    .OUT_W    (32),
    .NUM_BINS (NB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .num_bins  (num_bins),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_wdata(coef_wdata),
    .coef_busy (coef_busy),
    .out_power (out_power),
    .out_bin   (out_bin),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef logic signed [127:0] w_t;
  typedef struct {
    logic [31:0] pow;
    int          bin;
    bit          last;
  } exp_t;

  localparam w_t ACC_MAX = 128'sd2147483647;
  localparam w_t ACC_MIN = -128'sd2147483648;
  localparam w_t OUT_MAX = 128'sd4294967295;

  int          n_cmp = 0;
  int          n_bad = 0;
  w_t          m_s1 [NB];
  w_t          m_s2 [NB];
  int          m_coef [NB];
  int          m_nb = 0;
  bit          m_busy = 0;
  logic [31:0] m_pow [NB];
  logic [31:0] dut_pow [NB];
  int          n_emit = 0;
  exp_t        expq [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: one sample through every active bin, then per-bin power at frame end.
  task automatic model_sample(input int x, input bit last);
    w_t xv, c, s0, p;
    exp_t e;
    xv = x;
    for (int b = 0; b < m_nb; b++) begin
      c  = m_coef[b];
      s0 = xv + ((c * m_s1[b]) >>> 14) - m_s2[b];
      if (s0 > ACC_MAX) s0 = ACC_MAX;
      if (s0 < ACC_MIN) s0 = ACC_MIN;
      m_s2[b] = m_s1[b];
      m_s1[b] = s0;
    end
    if (last) begin
      for (int b = 0; b < m_nb; b++) begin
        c = m_coef[b];
        p = m_s1[b] * m_s1[b] + m_s2[b] * m_s2[b] - ((c * m_s1[b] * m_s2[b]) >>> 14);
        if (p < 0) p = 0;
        if (p > OUT_MAX) p = OUT_MAX;
        e.pow  = p[31:0];
        e.bin  = b;
        e.last = (b == m_nb - 1);
        m_pow[b] = p[31:0];
        expq.push_back(e);
        m_s1[b] = 0;
        m_s2[b] = 0;
      end
    end
  endtask

  task automatic model_clear();
    for (int b = 0; b < NB; b++) begin
      m_s1[b] = 0;
      m_s2[b] = 0;
    end
    m_busy = 0;
    expq.delete();
  endtask

  // Call at a negedge; returns at a negedge.
  task automatic wr_coef(input int a, input int v);
    coef_we    = 1'b1;
    coef_addr  = a[1:0];
    coef_wdata = v[17:0];
    if (!m_busy) m_coef[a] = v;
    @(posedge clk); #1;
    coef_we = 1'b0;
    @(negedge clk);
  endtask

  // Offer one sample (optionally with a same-cycle coef write), then check the in_ready gap.
  task automatic send(input int x, input bit last, input bit cw = 0, input int ca = 0, input int cv = 0);
    int t;
    t = 0;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("accept_timeout", in_ready, 1);
      return;
    end
    in_data  = x[15:0];
    in_valid = 1'b1;
    in_last  = last;
    if (cw) begin
      coef_we    = 1'b1;
      coef_addr  = ca[1:0];
      coef_wdata = cv[17:0];
      if (!m_busy) m_coef[ca] = cv;
    end
    if (!m_busy) begin
      m_nb   = (num_bins == 0 || num_bins > NB) ? NB : int'(num_bins);
      m_busy = 1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    coef_we  = 1'b0;
    model_sample(x, last);
    for (int k = 0; k < m_nb; k++) begin
      @(negedge clk);
      chk("in_ready_low", in_ready, 0);
      if (k == 0) chk("coef_busy_set", coef_busy, 1);
    end
    if (!last) begin
      @(negedge clk);
      chk("in_ready_back", in_ready, 1);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((expq.size() != 0 || out_valid) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("drain_left", expq.size(), 0);
    m_busy = 0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    chk("busy_clear", coef_busy, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    model_clear();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_coef_busy", coef_busy, 0);
  endtask

  task automatic frame_t1(input string tag);
    num_bins = 3'd1;
    send(1, 0);
    send(0, 0);
    send(-1, 0);
    send(0, 1);
    drain();
    chk({tag, "_model"}, m_pow[0], 4);
    chk({tag, "_dut"}, dut_pow[0], 4);
  endtask

  // Scoreboard: every output handshake against the model, plus hold stability under backpressure.
  task automatic monitor();
    exp_t        e;
    bit          held;
    logic [31:0] h_pow;
    logic [1:0]  h_bin;
    logic        h_last;
    held = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 0;
      end else begin
        if (held) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_power", out_power, h_pow);
          chk("hold_bin", out_bin, h_bin);
          chk("hold_last", out_last, h_last);
        end
        if (out_valid && out_ready) begin
          held = 0;
          if (expq.size() == 0) begin
            chk("unexpected_out", out_valid, 0);
          end else begin
            e = expq.pop_front();
            chk("power", out_power, e.pow);
            chk("bin", out_bin, e.bin);
            chk("last", out_last, e.last);
            dut_pow[out_bin] = out_power;
            n_emit++;
          end
        end else if (out_valid) begin
          held   = 1;
          h_pow  = out_power;
          h_bin  = out_bin;
          h_last = out_last;
        end else begin
          held = 0;
        end
      end
    end
  endtask

  initial begin
    int t;
    in_data    = '0;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    num_bins   = 3'd1;
    coef_we    = 1'b0;
    coef_addr  = '0;
    coef_wdata = '0;
    out_ready  = 1'b1;
    for (int b = 0; b < NB; b++) m_coef[b] = 0;
    model_clear();
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_coef_busy", coef_busy, 0);
    chk("reset_out_power", out_power, 0);
    chk("reset_out_bin", out_bin, 0);
    chk("reset_out_last", out_last, 0);

    // 1: single bin, coef 0.
    wr_coef(0, 0);
    frame_t1("t1");

    // 2: coef 2.0 written in the same cycle as the first sample.
    num_bins = 3'd1;
    send(100, 0, 1, 0, 32768);
    send(100, 0);
    send(100, 0);
    send(100, 1);
    drain();
    chk("t2_model", m_pow[0], 160000);
    chk("t2_dut", dut_pow[0], 160000);

    // 3: four bins; a coef write mid-frame must be dropped.
    wr_coef(1, 0);
    wr_coef(2, -16384);
    wr_coef(3, 23170);
    num_bins = 3'd4;
    send(1000, 0);
    wr_coef(1, 12345);
    send(-2000, 0);
    send(3000, 0);
    send(500, 1);
    drain();
    chk("t3_bin0_model", m_pow[0], 6250000);
    chk("t3_bin0_dut", dut_pow[0], 6250000);
    chk("t3_bin1_model", m_pow[1], 10250000);
    chk("t3_bin1_dut", dut_pow[1], 10250000);

    // 3b: num_bins=0 clamps to all bins; single-sample frame.
    num_bins = 3'd0;
    n_emit = 0;
    send(7, 1);
    drain();
    chk("t3b_emit_count", n_emit, 4);
    chk("t3b_bin3_dut", dut_pow[3], 49);

    // 4: backpressure during EMIT, then state must restart from zero.
    wr_coef(0, 0);
    out_ready = 1'b0;
    num_bins = 3'd1;
    send(1, 0);
    send(0, 0);
    send(-1, 0);
    send(0, 1);
    repeat (6) @(negedge clk);
    chk("t4_still_valid", out_valid, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();
    chk("t4_dut", dut_pow[0], 4);
    frame_t1("t4_repeat");

    // 5: large input with coef 2.0 -> power saturates.
    wr_coef(0, 32768);
    num_bins = 3'd1;
    for (int i = 0; i < 64; i++) send(32767, i == 63);
    drain();
    chk("t5_model", m_pow[0], 32'hFFFF_FFFF);
    chk("t5_dut", dut_pow[0], 32'hFFFF_FFFF);

    // 5b: coef near 8.0 drives s1/s2 to the positive rail; power goes negative -> 0.
    wr_coef(0, 131071);
    for (int i = 0; i < 20; i++) send(32767, i == 19);
    drain();
    chk("t5b_model_sat", m_s1[0] == 0 ? m_pow[0] : 32'd1, 0);
    chk("t5b_dut", dut_pow[0], 0);

    // 6a: reset during UPDATE.
    wr_coef(0, 0);
    num_bins  = 3'd4;
    in_data   = 16'd5;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t6a_busy_before", coef_busy, 1);
    do_reset();

    // 6b: reset during EMIT with output stalled.
    out_ready = 1'b0;
    num_bins  = 3'd1;
    send(1, 0);
    send(0, 0);
    send(-1, 0);
    send(0, 1);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("t6b_in_emit", out_valid, 1);
    do_reset();
    out_ready = 1'b1;
    frame_t1("t6_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
